// File: rtl/uarch_pkg.sv
// uarch_pkg: shared front-end constants, fetch FSM state type and fetch-packet size.
// Holds the machine widths (address, instruction, fetch width, buffer depth) used by
// fetch_ctrl and its in-flight PC queue.
package uarch_pkg;
    localparam int CPU_ADDR_BITS     = 32;
    localparam int CPU_INST_BITS     = 32;
    localparam int FETCH_WIDTH       = 2;
    localparam int INST_BUFFER_DEPTH = 8;
    localparam int FETCH_PKT_BYTES   = FETCH_WIDTH * 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_fifo.sv
// fetch_pc_fifo: in-order queue of PCs for I-Cache requests still awaiting a response.
// Ports: clk, rst_n (async active-low, the only clear), push/push_data (accepted request),
//        pop (response returned), head (PC of the oldest in-flight request).
// The owner never pushes beyond DEPTH entries nor pops when empty.
module fetch_pc_fifo
    import uarch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = CPU_ADDR_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = push ? nxt(wr_q) : wr_q;
        rd_d  = pop ? nxt(rd_q) : rd_q;
        if (push) mem_d[wr_q] = push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    assign head = mem_q[rd_q];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer owning the fetch PC, issuing aligned I-Cache requests,
// tagging responses with their PC into the instruction buffer under credit control,
// and flushing/restarting on backend redirects.
// Ports: clk, rst_n (async active-low); icache_req_val/rdy/addr (request channel);
//        icache_resp_val/data (in-order responses); buf_wr_val/pc/data (buffer write);
//        buf_pop (buffer consumed a packet); buf_flush (flush pulse);
//        redirect_val/pc (backend redirect).
// Optional FETCH_CTRL_PERF_EN adds saturating counters perf_redirects,
// perf_credit_stalls and perf_drops with matching output ports.
module fetch_ctrl
    import uarch_pkg::*;
#(
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = 32'h0000_0000,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    output logic                                 icache_req_val,
    input  logic                                 icache_req_rdy,
    output logic [CPU_ADDR_BITS-1:0]             icache_req_addr,
    input  logic                                 icache_resp_val,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_resp_data,
    output logic                                 buf_wr_val,
    output logic [CPU_ADDR_BITS-1:0]             buf_wr_pc,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] buf_wr_data,
    input  logic                                 buf_pop,
    output logic                                 buf_flush,
    input  logic                                 redirect_val,
    input  logic [CPU_ADDR_BITS-1:0]             redirect_pc
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]                          perf_redirects,
    output logic [31:0]                          perf_credit_stalls,
    output logic [31:0]                          perf_drops
`endif
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(INST_BUFFER_DEPTH + 2);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CMAX  = CW'(INST_BUFFER_DEPTH - 1);

    fetch_state_t             state_q, state_d;
    logic [CPU_ADDR_BITS-1:0] pc_q, pc_d, head_pc;
    logic [CW-1:0]            credits_q, credits_d, credit_sum;
    logic [OW-1:0]            outstanding_q, outstanding_d, stale_q, stale_d, new_stale;
    logic                     resp, drop, accept, unused_lsb;

    assign unused_lsb = ^redirect_pc[2:0];

    always_comb begin
        // A response with nothing in flight cannot be ours; ignoring it keeps the queue sane.
        resp           = icache_resp_val && outstanding_q != '0;
        drop           = resp && (redirect_val || stale_q != '0);
        icache_req_val = state_q == RUN && credits_q != '0 && outstanding_q < MAX_O && !redirect_val;
        accept         = icache_req_val && icache_req_rdy;
        new_stale      = outstanding_q - OW'(resp);
        credit_sum     = credits_q + CW'(buf_pop) + CW'(drop) - CW'(accept);
        pc_d           = accept ? pc_q + CPU_ADDR_BITS'(FETCH_PKT_BYTES) : pc_q;
        outstanding_d  = outstanding_q + OW'(accept) - OW'(resp);
        stale_d        = stale_q - OW'(drop);
        credits_d      = credit_sum > CMAX ? CMAX : credit_sum;
        // Leave DRAIN as the last stale response retires so fetch resumes the next cycle.
        state_d        = state_q == DRAIN && stale_d != '0 ? DRAIN : RUN;
        if (redirect_val) begin
            // Every request still in flight becomes stale and holds its credit until dropped.
            pc_d          = {redirect_pc[CPU_ADDR_BITS-1:3], 3'b000};
            outstanding_d = new_stale;
            stale_d       = new_stale;
            credits_d     = CMAX - CW'(new_stale);
            state_d       = new_stale != '0 ? DRAIN : RUN;
        end
        buf_wr_val      = resp && !drop;
        buf_wr_pc       = buf_wr_val ? head_pc : '0;
        buf_wr_data     = buf_wr_val ? icache_resp_data : '0;
        buf_flush       = redirect_val;
        icache_req_addr = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            credits_q     <= CMAX;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    fetch_pc_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .W    (CPU_ADDR_BITS)
    ) u_pc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_data(pc_q),
        .pop      (resp),
        .head     (head_pc)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_credit_stalls_q, perf_credit_stalls_d;
    logic [31:0] perf_drops_q, perf_drops_d;

    always_comb begin
        perf_redirects_d     = redirect_val && perf_redirects_q != '1 ? perf_redirects_q + 32'd1 : perf_redirects_q;
        perf_credit_stalls_d = state_q == RUN && credits_q == '0 && perf_credit_stalls_q != '1 ?
                               perf_credit_stalls_q + 32'd1 : perf_credit_stalls_q;
        perf_drops_d         = drop && perf_drops_q != '1 ? perf_drops_q + 32'd1 : perf_drops_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects_q     <= '0;
            perf_credit_stalls_q <= '0;
            perf_drops_q         <= '0;
        end else begin
            perf_redirects_q     <= perf_redirects_d;
            perf_credit_stalls_q <= perf_credit_stalls_d;
            perf_drops_q         <= perf_drops_d;
        end
    end

    assign perf_redirects     = perf_redirects_q;
    assign perf_credit_stalls = perf_credit_stalls_q;
    assign perf_drops         = perf_drops_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl with an I-Cache and instruction-buffer model.
// Credits are predicted as buffer capacity minus everything in flight minus buffer occupancy.
module tb_fetch_ctrl;
    import uarch_pkg::*;

    localparam int AW   = CPU_ADDR_BITS;
    localparam int DW   = FETCH_WIDTH * CPU_INST_BITS;
    localparam int MAXO = 2;
    localparam int CMAX = INST_BUFFER_DEPTH - 1;
    localparam logic [AW-1:0] RPC = 32'h0000_0000;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } fl_t;

    logic          clk = 0;
    logic          rst_n;
    logic          icache_req_val, icache_req_rdy;
    logic [AW-1:0] icache_req_addr;
    logic          icache_resp_val;
    logic [DW-1:0] icache_resp_data;
    logic          buf_wr_val, buf_pop, buf_flush, redirect_val;
    logic [AW-1:0] buf_wr_pc, redirect_pc;
    logic [DW-1:0] buf_wr_data;

    int            chk = 0, err = 0;
    int            cyc = 0, occ = 0, stale = 0, wr_cnt = 0;
    int            p_rdy, p_resp, p_pop, p_redir, max_lat;
    bit            started;
    logic [AW-1:0] m_pc;
    fl_t           iq[$];

    fetch_ctrl #(
        .RESET_PC       (RPC),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icache_req_val  (icache_req_val),
        .icache_req_rdy  (icache_req_rdy),
        .icache_req_addr (icache_req_addr),
        .icache_resp_val (icache_resp_val),
        .icache_resp_data(icache_resp_data),
        .buf_wr_val      (buf_wr_val),
        .buf_wr_pc       (buf_wr_pc),
        .buf_wr_data     (buf_wr_data),
        .buf_pop         (buf_pop),
        .buf_flush       (buf_flush),
        .redirect_val    (redirect_val),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        icache_req_rdy   = 0;
        icache_resp_val  = 0;
        icache_resp_data = '0;
        buf_pop          = 0;
        redirect_val     = 0;
        redirect_pc      = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        idle_inputs();
        #1;
        check("rst_req_val", icache_req_val, 0);
        check("rst_req_addr", icache_req_addr, RPC);
        check("rst_wr_val", buf_wr_val, 0);
        check("rst_wr_pc", buf_wr_pc, 0);
        check("rst_wr_data", buf_wr_data, 0);
        check("rst_flush", buf_flush, 0);
        iq.delete();
        occ     = 0;
        stale   = 0;
        m_pc    = RPC;
        started = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    task automatic step();
        fl_t e;
        bit  rv, wr, exp_req, acc;
        int  cr;
        @(negedge clk);
        cr               = CMAX - iq.size() - occ;
        icache_req_rdy   = $urandom_range(99) < p_rdy;
        rv               = iq.size() > 0 && iq[0].due <= cyc && $urandom_range(99) < p_resp;
        icache_resp_val  = rv;
        icache_resp_data = rv ? iq[0].data : {$urandom, $urandom};
        buf_pop          = occ > 0 && $urandom_range(99) < p_pop;
        redirect_val     = $urandom_range(99) < p_redir;
        redirect_pc      = $urandom;
        #1;
        exp_req = started && stale == 0 && cr > 0 && iq.size() < MAXO && !redirect_val;
        wr      = rv && stale == 0 && !redirect_val;
        check("req_val", icache_req_val, exp_req);
        check("req_addr", icache_req_addr, m_pc);
        check("wr_val", buf_wr_val, wr);
        check("flush", buf_flush, redirect_val);
        if (wr) begin
            check("wr_pc", buf_wr_pc, iq[0].addr);
            check("wr_data", buf_wr_data, iq[0].data);
            wr_cnt++;
        end
        acc = exp_req && icache_req_rdy;
        if (rv) begin
            void'(iq.pop_front());
            if (stale > 0) stale--;
            else if (!redirect_val) occ++;
        end
        if (redirect_val) begin
            stale = iq.size();
            occ   = 0;
            m_pc  = {redirect_pc[AW-1:3], 3'b000};
        end else begin
            if (buf_pop) occ--;
            if (acc) begin
                e.addr = m_pc;
                e.data = {$urandom, $urandom};
                e.due  = cyc + $urandom_range(max_lat, 1);
                iq.push_back(e);
                m_pc = m_pc + AW'(FETCH_PKT_BYTES);
            end
        end
        started = 1;
        cyc++;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        do_reset();
        p_rdy = 100; p_resp = 100; p_pop = 0; p_redir = 0; max_lat = 1;
        wr_cnt = 0;
        repeat (20) step();
        check("fill_writes", wr_cnt, CMAX);
        p_pop = 100;
        step();
        p_pop = 0;
        repeat (6) step();
        p_pop = 100;
        repeat (3) step();
        p_pop = 0; p_rdy = 0;
        repeat (5) step();
        p_rdy = 100;
        repeat (4) step();
        p_rdy = 70; p_resp = 70; p_pop = 50; p_redir = 5; max_lat = 3;
        repeat (3000) step();
        p_resp = 30; p_redir = 20;
        repeat (1000) step();
        p_resp = 70; p_redir = 5;
        repeat (200) step();
        do_reset();
        repeat (500) step();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
